// File: rtl/uart_rx_buffer.sv
// 8N1 UART receiver feeding a byte FIFO, exposed as a DATA/STATUS register pair.
// Define UART_RX_PARITY_EN to add an even-parity bit between DATA and STOP.
module uart_rx_buffer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        reg_sel,
  input  logic [7:0]  wdata,
  input  logic        wenable,
  output logic [31:0] rdata,
  output logic        int_pending
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LP_BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LP_HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]   LP_FULL     = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t         r_state;
  logic           r_rx_meta;
  logic           r_rx_sync;
  logic [CW-1:0]  r_cnt;
  logic [2:0]     r_bit_cnt;
  logic [7:0]     r_shift;
  logic           r_ovr;
  logic           r_ferr;
`ifdef UART_RX_PARITY_EN
  logic           r_par_bad;
  logic           r_perr;
`endif

  logic [AW:0]    r_wr_ptr;
  logic [AW:0]    r_rd_ptr;
  logic [7:0]     r_mem [FIFO_DEPTH];

  logic           w_bit_tick;
  logic           w_stop_tick;
  logic           w_frame_ok;
  logic           w_ferr_set;
  logic [AW:0]    w_count;
  logic [8:0]     w_count_ext;
  logic           w_empty;
  logic           w_full;
  logic           w_pop;
  logic           w_push;
  logic           w_ovr_set;
  logic           w_clr;
  logic           w_unused;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  assign w_bit_tick  = (r_cnt == LP_BIT_END);
  assign w_stop_tick = (r_state == S_STOP) && w_bit_tick;
  assign w_ferr_set  = w_stop_tick && !r_rx_sync;
`ifdef UART_RX_PARITY_EN
  assign w_frame_ok  = w_stop_tick && r_rx_sync && !r_par_bad;
`else
  assign w_frame_ok  = w_stop_tick && r_rx_sync;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_rx_sync) begin
            r_cnt   <= '0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (r_cnt == LP_HALF_END) begin
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_state   <= r_rx_sync ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_tick) begin
            r_cnt     <= '0;
            r_shift   <= {r_rx_sync, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_bit_tick) begin
            r_cnt     <= '0;
            r_par_bad <= r_rx_sync ^ (^r_shift);
            r_state   <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`endif
        S_STOP: begin
          if (w_bit_tick) begin
            r_cnt   <= '0;
            r_state <= r_rx_sync ? S_IDLE : S_BREAK;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_BREAK: begin
          if (r_rx_sync) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_count     = r_wr_ptr - r_rd_ptr;
  assign w_count_ext = 9'(w_count);
  assign w_empty     = (w_count == '0);
  assign w_full      = (w_count == LP_FULL);
  assign w_pop       = wenable && !reg_sel && !w_empty;
  // A pop in the same cycle frees the head slot, so a push into a full FIFO still fits.
  assign w_push      = w_frame_ok && (!w_full || w_pop);
  assign w_ovr_set   = w_frame_ok && w_full && !w_pop;
  assign w_clr       = wenable && reg_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovr    <= 1'b0;
      r_ferr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr   <= 1'b0;
`endif
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
      r_ovr  <= w_ovr_set  | (r_ovr  & ~(w_clr & wdata[2]));
      r_ferr <= w_ferr_set | (r_ferr & ~(w_clr & wdata[3]));
`ifdef UART_RX_PARITY_EN
      r_perr <= (w_stop_tick & r_par_bad) | (r_perr & ~(w_clr & wdata[4]));
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
  end

  always_comb begin
    rdata = '0;
    if (reg_sel) begin
      rdata[0]    = !w_empty;
      rdata[1]    = w_full;
      rdata[2]    = r_ovr;
      rdata[3]    = r_ferr;
`ifdef UART_RX_PARITY_EN
      rdata[4]    = r_perr;
`endif
      rdata[15:8] = w_count_ext[7:0];
    end else if (!w_empty) begin
      rdata[7:0] = r_mem[r_rd_ptr[AW-1:0]];
    end
  end

  assign int_pending = !w_empty;

`ifdef UART_RX_PARITY_EN
  assign w_unused = ^{wdata[7:5], wdata[1:0], w_count_ext[8]};
`else
  assign w_unused = ^{wdata[7:4], wdata[1:0], w_count_ext[8]};
`endif

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed self-checking bench for uart_rx_buffer (CLKS_PER_BIT=16, FIFO_DEPTH=16).
module tb_uart_rx_buffer;

  localparam int CPB   = 16;
  localparam int DEPTH = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS    = 10;
  localparam int STOP_NEG = 170;
`else
  localparam int NBITS    = 9;
  localparam int STOP_NEG = 154;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        reg_sel;
  logic [7:0]  wdata;
  logic        wenable;
  logic [31:0] rdata;
  logic        int_pending;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] v;

  always #5 clk = ~clk;

  uart_rx_buffer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .reg_sel     (reg_sel),
    .wdata       (wdata),
    .wenable     (wenable),
    .rdata       (rdata),
    .int_pending (int_pending)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic sel, output logic [31:0] val);
    reg_sel = sel;
    #1;
    val = rdata;
  endtask

  task automatic wr(input logic sel, input logic [7:0] d);
    @(negedge clk);
    reg_sel = sel;
    wdata   = d;
    wenable = 1'b1;
    @(negedge clk);
    wenable = 1'b0;
  endtask

  // Frame bits LSB first: start, 8 data, optional parity; then stop held stop_len cycles.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stopb,
                            input int stop_len);
    logic [9:0] bits;
    bits = {par, d, 1'b0};
    @(negedge clk);
    for (int i = 0; i < NBITS; i++) begin
      rx = bits[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stopb;
    repeat (stop_len) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rx = 1'b1; reg_sel = 1'b0; wdata = '0; wenable = 1'b0;
    repeat (3) @(negedge clk);
    rd(1'b0, v); check("reset_data", v, 32'h0);
    rd(1'b1, v); check("reset_status", v, 32'h0);
    check("reset_int", {31'b0, int_pending}, 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single byte with exact push timing
    fork
      send_frame(8'hA5, ^8'hA5, 1'b1, CPB);
      begin
        @(negedge clk);
        repeat (STOP_NEG) @(negedge clk);
        rd(1'b1, v); check("a5_status_before_push", v, 32'h0);
        @(negedge clk);
        rd(1'b1, v); check("a5_status_after_push", v, 32'h0101);
        check("a5_int", {31'b0, int_pending}, 32'h1);
      end
    join
    rd(1'b0, v); check("a5_data", v, 32'h0000_00A5);
    rd(1'b0, v); check("a5_data_reread", v, 32'h0000_00A5);
    wr(1'b0, 8'h00);
    rd(1'b1, v); check("a5_status_popped", v, 32'h0);
    check("a5_int_popped", {31'b0, int_pending}, 32'h0);
    rd(1'b0, v); check("empty_data", v, 32'h0);
    wr(1'b0, 8'h00);
    rd(1'b1, v); check("pop_when_empty", v, 32'h0);

    // Overflow: 17 bytes into a 16-deep FIFO
    for (int i = 0; i <= 16; i++) send_frame(8'(i), ^(8'(i)), 1'b1, CPB);
    rd(1'b1, v); check("ovf_status", v, 32'h1007);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rd(1'b0, v); check("ovf_data", v, 32'(i));
      wr(1'b0, 8'hFF);
    end
    rd(1'b1, v); check("ovf_status_drained", v, 32'h0004);
    wr(1'b1, 8'h00);
    rd(1'b1, v); check("ovr_write_zero_keeps", v, 32'h0004);
    wr(1'b1, 8'h04);
    rd(1'b1, v); check("ovr_cleared", v, 32'h0);

    // Short glitch is a false start
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    rd(1'b1, v); check("glitch_status", v, 32'h0);

    // Framing error then recovery
    send_frame(8'h3C, ^8'h3C, 1'b0, 40);
    rd(1'b1, v); check("ferr_status", v, 32'h0008);
    send_frame(8'h55, ^8'h55, 1'b1, CPB);
    rd(1'b1, v); check("after_ferr_status", v, 32'h0109);
    rd(1'b0, v); check("after_ferr_data", v, 32'h0000_0055);
    wr(1'b1, 8'h08);
    rd(1'b1, v); check("ferr_cleared", v, 32'h0101);
    wr(1'b0, 8'h00);
    rd(1'b1, v); check("ferr_drained", v, 32'h0);

    // Full FIFO with a pop on the push cycle
    for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), ^(8'h20 + 8'(i)), 1'b1, CPB);
    rd(1'b1, v); check("full_status", v, 32'h1003);
    fork
      send_frame(8'h77, ^8'h77, 1'b1, CPB);
      begin
        @(negedge clk);
        repeat (STOP_NEG) @(negedge clk);
        reg_sel = 1'b0;
        wenable = 1'b1;
        @(negedge clk);
        wenable = 1'b0;
      end
    join
    rd(1'b1, v); check("pushpop_status", v, 32'h1003);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rd(1'b0, v); check("pushpop_data", v, (i < 15) ? 32'h21 + 32'(i) : 32'h77);
      wr(1'b0, 8'h00);
    end
    rd(1'b1, v); check("pushpop_drained", v, 32'h0);

    // Reset mid-frame discards the partial byte; remaining bits are all idle-high
    fork
      send_frame(8'hFE, 1'b1, 1'b1, CPB);
      begin
        repeat (70) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
      end
    join
    rd(1'b1, v); check("midframe_reset_status", v, 32'h0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h01, 1'b0, 1'b1, CPB);
    rd(1'b1, v); check("perr_status", v, 32'h0010);
    send_frame(8'h03, 1'b0, 1'b1, CPB);
    rd(1'b1, v); check("par_ok_status", v, 32'h0111);
    rd(1'b0, v); check("par_ok_data", v, 32'h0000_0003);
    wr(1'b1, 8'h10);
    rd(1'b1, v); check("perr_cleared", v, 32'h0101);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
